// File: rtl/conway_pkg.sv
// Shared types and sizes for the serial cell evaluator: FSM states,
// neighbour count and count width.
package conway_pkg;

    localparam int NUM_NEIGHBORS = 8;
    localparam int COUNT_W       = 4;
    localparam int BEAT_W        = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        RESULT = 2'd2
    } state_t;

endpackage

// File: rtl/conway_rule.sv
// Combinational life/death rule: survival window for live cells,
// exact birth count for dead cells.
module conway_rule
    import conway_pkg::*;
#(
    parameter int BIRTH_COUNT = 3,
    parameter int SURVIVE_MIN = 2,
    parameter int SURVIVE_MAX = 3
) (
    input  logic               alive,
    input  logic [COUNT_W-1:0] count,
    output logic               next_alive
);

    localparam logic [COUNT_W-1:0] BIRTH_C = COUNT_W'(BIRTH_COUNT);
    localparam logic [COUNT_W-1:0] SMIN_C  = COUNT_W'(SURVIVE_MIN);
    localparam logic [COUNT_W-1:0] SMAX_C  = COUNT_W'(SURVIVE_MAX);

    always_comb begin
        if (alive) begin
            next_alive = (count >= SMIN_C) && (count <= SMAX_C);
        end else begin
            next_alive = (count == BIRTH_C);
        end
    end

endmodule

// File: rtl/serial_cell_evaluator.sv
// Accepts one cell state plus eight serial neighbour bits and hands back
// the next-generation state over a valid/ready handshake.
module serial_cell_evaluator
    import conway_pkg::*;
#(
    parameter int BIRTH_COUNT = 3,
    parameter int SURVIVE_MIN = 2,
    parameter int SURVIVE_MAX = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               cell_alive,
    input  logic               nbr_valid,
    input  logic               nbr_bit,
    output logic               nbr_ready,
    output logic               next_valid,
    output logic               next_alive,
    input  logic               next_ready,
    output logic               busy,
    output logic [COUNT_W-1:0] neighbor_count
);

    state_t              state_reg, state_next;
    logic [BEAT_W-1:0]   beat_reg;
    logic [COUNT_W-1:0]  count_reg;
    logic                cell_reg;
    logic                next_alive_reg;

    logic                accept;
    logic                last_beat;
    logic [COUNT_W-1:0]  count_sum;
    logic                rule_alive;

    assign accept    = (state_reg == ACCUM) && nbr_valid;
    assign last_beat = accept && (beat_reg == BEAT_W'(NUM_NEIGHBORS - 1));
    assign count_sum = count_reg + {{(COUNT_W-1){1'b0}}, nbr_bit};

    // The rule sees the count including the beat being accepted, so the
    // result is registered on the same edge as the final beat.
    conway_rule #(
        .BIRTH_COUNT (BIRTH_COUNT),
        .SURVIVE_MIN (SURVIVE_MIN),
        .SURVIVE_MAX (SURVIVE_MAX)
    ) u_rule (
        .alive      (cell_reg),
        .count      (count_sum),
        .next_alive (rule_alive)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start)      state_next = ACCUM;
            ACCUM:   if (last_beat)  state_next = RESULT;
            RESULT:  if (next_ready) state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_comb begin
        nbr_ready  = (state_reg == ACCUM);
        next_valid = (state_reg == RESULT);
        busy       = (state_reg != IDLE);
    end

    // Datapath: count and result persist through IDLE until the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_reg       <= '0;
            count_reg      <= '0;
            cell_reg       <= 1'b0;
            next_alive_reg <= 1'b0;
        end else begin
            if (state_reg == IDLE && start) begin
                cell_reg  <= cell_alive;
                count_reg <= '0;
                beat_reg  <= '0;
            end
            if (accept) begin
                count_reg <= count_sum;
                beat_reg  <= beat_reg + BEAT_W'(1);
            end
            if (last_beat) begin
                next_alive_reg <= rule_alive;
            end
        end
    end

    assign next_alive     = next_alive_reg;
    assign neighbor_count = count_reg;

endmodule

// File: tb/tb_serial_cell_evaluator.sv
// Directed bench for serial_cell_evaluator: a table of evaluations plus
// hand-written sequences for back-pressure and mid-evaluation reset.
module tb_serial_cell_evaluator;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       start      = 1'b0;
    logic       cell_alive = 1'b0;
    logic       nbr_valid  = 1'b0;
    logic       nbr_bit    = 1'b0;
    logic       next_ready = 1'b0;
    logic       nbr_ready;
    logic       next_valid;
    logic       next_alive;
    logic       busy;
    logic [3:0] neighbor_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       alive;
        logic [7:0] bits;   // bit 0 is sent first
        logic [7:0] gaps;   // gaps[i]=1: two idle cycles before beat i
        logic [3:0] exp_count;
        logic       exp_next;
    } vec_t;

    vec_t vecs[10];

    serial_cell_evaluator dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .cell_alive     (cell_alive),
        .nbr_valid      (nbr_valid),
        .nbr_bit        (nbr_bit),
        .nbr_ready      (nbr_ready),
        .next_valid     (next_valid),
        .next_alive     (next_alive),
        .next_ready     (next_ready),
        .busy           (busy),
        .neighbor_count (neighbor_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Runs start plus eight beats; returns at the first RESULT cycle with
    // lat = cycles counted from the cycle start was driven (cycle 0).
    task automatic accum(input logic a, input logic [7:0] bits, input logic [7:0] gaps,
                         output int lat);
        int run;
        run = 0;
        lat = 0;
        @(negedge clk);
        start      = 1'b1;
        cell_alive = a;
        @(negedge clk);
        lat++;
        start = 1'b0;
        check("accum_busy", 8'(busy), 8'd1);
        check("accum_ready", 8'(nbr_ready), 8'd1);
        check("accum_clear", 8'(neighbor_count), 8'd0);
        for (int i = 0; i < 8; i++) begin
            if (gaps[i]) begin
                nbr_valid = 1'b0;
                repeat (2) begin
                    @(negedge clk);
                    lat++;
                    check("stall_count", 8'(neighbor_count), 8'(run));
                end
            end
            check("accum_valid_low", 8'(next_valid), 8'd0);
            nbr_valid = 1'b1;
            nbr_bit   = bits[i];
            @(negedge clk);
            lat++;
            run += int'(bits[i]);
            check("beat_count", 8'(neighbor_count), 8'(run));
        end
        nbr_valid = 1'b0;
        nbr_bit   = 1'b0;
    endtask

    initial begin
        int lat;
        vecs[0] = '{1'b1, 8'b0000_0011, 8'h00,        4'd2, 1'b1};
        vecs[1] = '{1'b0, 8'b1001_0010, 8'b0101_0101, 4'd3, 1'b1};
        vecs[2] = '{1'b0, 8'b0100_0001, 8'b1000_0010, 4'd2, 1'b0};
        vecs[3] = '{1'b1, 8'hFF,        8'h00,        4'd8, 1'b0};
        vecs[4] = '{1'b1, 8'h00,        8'h00,        4'd0, 1'b0};
        vecs[5] = '{1'b1, 8'b1110_0000, 8'b0010_0000, 4'd3, 1'b1};
        vecs[6] = '{1'b1, 8'b1010_1010, 8'h00,        4'd4, 1'b0};
        vecs[7] = '{1'b0, 8'b0000_1111, 8'h00,        4'd4, 1'b0};
        vecs[8] = '{1'b1, 8'b1000_0000, 8'h00,        4'd1, 1'b0};
        vecs[9] = '{1'b0, 8'b0111_0000, 8'h00,        4'd3, 1'b1};

        #12;
        check("rst_next_valid", 8'(next_valid), 8'd0);
        check("rst_next_alive", 8'(next_alive), 8'd0);
        check("rst_nbr_ready", 8'(nbr_ready), 8'd0);
        check("rst_busy", 8'(busy), 8'd0);
        check("rst_count", 8'(neighbor_count), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 10; v++) begin
            accum(vecs[v].alive, vecs[v].bits, vecs[v].gaps, lat);
            check("result_valid", 8'(next_valid), 8'd1);
            check("result_count", 8'(neighbor_count), 8'(vecs[v].exp_count));
            check("result_alive", 8'(next_alive), 8'(vecs[v].exp_next));
            check("result_busy", 8'(busy), 8'd1);
            check("result_nbr_ready", 8'(nbr_ready), 8'd0);
            if (vecs[v].gaps == 8'h00) check("latency", 8'(lat), 8'd9);
            next_ready = 1'b1;
            @(negedge clk);
            next_ready = 1'b0;
            check("idle_valid", 8'(next_valid), 8'd0);
            check("idle_busy", 8'(busy), 8'd0);
            check("idle_count_hold", 8'(neighbor_count), 8'(vecs[v].exp_count));
            check("idle_alive_hold", 8'(next_alive), 8'(vecs[v].exp_next));
            $display("eval %0d alive=%0b count=%0d next_alive=%0b latency=%0d",
                     v, vecs[v].alive, neighbor_count, next_alive, lat);
        end

        // Back-pressure: result held five cycles while start pulses.
        accum(1'b1, 8'b0000_0111, 8'h00, lat);
        for (int k = 0; k < 5; k++) begin
            start = (k % 2 == 0);
            @(negedge clk);
            check("hold_valid", 8'(next_valid), 8'd1);
            check("hold_alive", 8'(next_alive), 8'd1);
            check("hold_count", 8'(neighbor_count), 8'd3);
            check("hold_busy", 8'(busy), 8'd1);
        end
        next_ready = 1'b1;
        start      = 1'b1;
        @(negedge clk);
        next_ready = 1'b0;
        start      = 1'b0;
        check("hs_start_ignored_busy", 8'(busy), 8'd0);
        check("hs_valid", 8'(next_valid), 8'd0);
        @(negedge clk);
        check("hs_idle_busy", 8'(busy), 8'd0);
        $display("eval hold count=%0d next_alive=%0b", neighbor_count, next_alive);

        // Reset mid-accumulation after four beats, checked without a clock edge.
        @(negedge clk);
        start      = 1'b1;
        cell_alive = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        nbr_valid = 1'b1;
        nbr_bit   = 1'b1;
        repeat (4) @(negedge clk);
        nbr_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 8'(next_valid), 8'd0);
        check("arst_alive", 8'(next_alive), 8'd0);
        check("arst_nbr_ready", 8'(nbr_ready), 8'd0);
        check("arst_busy", 8'(busy), 8'd0);
        check("arst_count", 8'(neighbor_count), 8'd0);
        @(negedge clk);
        check("arst_no_result", 8'(next_valid), 8'd0);
        rst_n      = 1'b1;
        start      = 1'b1;
        cell_alive = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("post_rst_start", 8'(busy), 8'd1);
        for (int i = 0; i < 8; i++) begin
            nbr_valid = 1'b1;
            nbr_bit   = (i == 0 || i == 2 || i == 4);
            @(negedge clk);
        end
        nbr_valid = 1'b0;
        nbr_bit   = 1'b0;
        check("post_rst_valid", 8'(next_valid), 8'd1);
        check("post_rst_count", 8'(neighbor_count), 8'd3);
        check("post_rst_alive", 8'(next_alive), 8'd1);
        next_ready = 1'b1;
        @(negedge clk);
        next_ready = 1'b0;
        check("post_rst_idle", 8'(busy), 8'd0);
        $display("eval post_reset count=%0d next_alive=%0b", neighbor_count, next_alive);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
